// File: rtl/hazard_ctrl_if.sv
// Purpose: ID-stage operand/control bundle between the datapath and hazard_ctrl.
// Latency: none; plain signal grouping.
// Backpressure: carried by stall_if/freeze back to the datapath.
interface hazard_ctrl_if #(
  parameter int AWIDTH    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int CNT_WIDTH = 16
);
  localparam int FW = $clog2(FWD_DEPTH + 1);

  logic              hc_i_ce;
  logic              hc_i_valid_id;
  logic [AWIDTH-1:0] hc_i_rs;
  logic [AWIDTH-1:0] hc_i_rt;
  logic              hc_i_use_rs;
  logic              hc_i_use_rt;
  logic              hc_i_regwr;
  logic [AWIDTH-1:0] hc_i_rd;
  logic              hc_i_is_load;
  logic              hc_i_redirect;
  logic              hc_i_mem_busy;

  logic                 hc_o_stall_if;
  logic                 hc_o_bubble_ex;
  logic                 hc_o_flush;
  logic                 hc_o_freeze;
  logic [FW-1:0]        hc_o_fwd_rs;
  logic [FW-1:0]        hc_o_fwd_rt;
  logic [CNT_WIDTH-1:0] hc_o_stall_cnt;

  // Datapath side: presents the ID instruction, obeys the pipeline controls.
  modport master (
    output hc_i_ce, hc_i_valid_id, hc_i_rs, hc_i_rt, hc_i_use_rs, hc_i_use_rt,
           hc_i_regwr, hc_i_rd, hc_i_is_load, hc_i_redirect, hc_i_mem_busy,
    input  hc_o_stall_if, hc_o_bubble_ex, hc_o_flush, hc_o_freeze,
           hc_o_fwd_rs, hc_o_fwd_rt, hc_o_stall_cnt
  );

  // Controller side.
  modport slave (
    input  hc_i_ce, hc_i_valid_id, hc_i_rs, hc_i_rt, hc_i_use_rs, hc_i_use_rt,
           hc_i_regwr, hc_i_rd, hc_i_is_load, hc_i_redirect, hc_i_mem_busy,
    output hc_o_stall_if, hc_o_bubble_ex, hc_o_flush, hc_o_freeze,
           hc_o_fwd_rs, hc_o_fwd_rt, hc_o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: scoreboard-based forwarding select, load-use stall, redirect flush and memory freeze.
// Latency: all controls combinational in the same cycle; state advances on the rising edge.
// Backpressure: mem_busy freezes every register here; stalls hold IF/ID and bubble ID/EX.
module hazard_ctrl #(
  parameter int AWIDTH      = 5,
  parameter int FWD_DEPTH   = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input logic          hc_clk,
  input logic          hc_rst,
  hazard_ctrl_if.slave hc
);
  localparam int FW  = $clog2(FWD_DEPTH + 1);
  localparam int FCW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [FCW-1:0] FRELOAD = FCW'(FLUSH_DEPTH - 1);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [AWIDTH-1:0] rd;
    logic              ld;
  } sb_ent_t;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  sb_ent_t              sb [FWD_DEPTH];
  sb_ent_t              new_ent;
  state_t               state;
  logic [FCW-1:0]       fcnt;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic [FW-1:0] rs_sel, rt_sel;
  logic          rs_lu, rt_lu;
  logic          run, frz, flush_req, fl, lu, issue;

  // Nearest matching producer per source; descending scan lets the youngest slot win.
  always_comb begin
    rs_sel = '0;
    rs_lu  = 1'b0;
    rt_sel = '0;
    rt_lu  = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (sb[k].vld && sb[k].wr && hc.hc_i_use_rs && (hc.hc_i_rs != '0) && (sb[k].rd == hc.hc_i_rs)) begin
        rs_sel = FW'(k + 1);
        rs_lu  = sb[k].ld && (k < LOAD_LAT);
      end
      if (sb[k].vld && sb[k].wr && hc.hc_i_use_rt && (hc.hc_i_rt != '0) && (sb[k].rd == hc.hc_i_rt)) begin
        rt_sel = FW'(k + 1);
        rt_lu  = sb[k].ld && (k < LOAD_LAT);
      end
    end
  end

  // Priority: disabled/reset, freeze, flush, load-use stall, normal issue.
  assign run       = hc_rst && hc.hc_i_ce;
  assign frz       = run && hc.hc_i_mem_busy;
  assign flush_req = hc.hc_i_redirect || (state == S_FLUSH);
  assign fl        = run && !hc.hc_i_mem_busy && flush_req;
  assign lu        = run && !hc.hc_i_mem_busy && !flush_req && (rs_lu || rt_lu);
  assign issue     = hc.hc_i_valid_id && !lu && !flush_req;

  // Destination r0 never produces a forwardable value, so it is entered as non-writing.
  assign new_ent = issue ? {1'b1, hc.hc_i_regwr && (hc.hc_i_rd != '0), hc.hc_i_rd, hc.hc_i_is_load}
                         : '0;

  assign hc.hc_o_freeze    = frz;
  assign hc.hc_o_stall_if  = frz || lu;
  assign hc.hc_o_bubble_ex = lu;
  assign hc.hc_o_flush     = fl;
  assign hc.hc_o_fwd_rs    = run ? rs_sel : '0;
  assign hc.hc_o_fwd_rt    = run ? rt_sel : '0;
  assign hc.hc_o_stall_cnt = run ? stall_cnt_q : '0;

  // Scoreboard: shift one stage per unfrozen cycle, youngest entry (or bubble) into slot 0.
  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
    end else if (!hc.hc_i_ce) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
    end else if (!hc.hc_i_mem_busy) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) sb[k] <= sb[k-1];
      sb[0] <= new_ent;
    end
  end

  // Flush FSM: the redirect cycle flushes, then FLUSH_DEPTH-1 more cycles; a new redirect reloads.
  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      state <= S_RUN;
      fcnt  <= '0;
    end else if (!hc.hc_i_ce) begin
      state <= S_RUN;
      fcnt  <= '0;
    end else if (!hc.hc_i_mem_busy) begin
      if (hc.hc_i_redirect) begin
        if (FLUSH_DEPTH > 1) begin
          state <= S_FLUSH;
          fcnt  <= FRELOAD;
        end
      end else if (state == S_FLUSH) begin
        if (fcnt == FCW'(1)) begin
          state <= S_RUN;
          fcnt  <= '0;
        end else begin
          fcnt <= fcnt - 1'b1;
        end
      end
    end
  end

  // Saturating count of load-use stall cycles; survives ce dropping, cleared only by reset.
  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      stall_cnt_q <= '0;
    end else if (lu && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the MIPS pipeline. It replaces the fixed two-source forwarding and load-use logic. The block tracks the destination registers of in-flight instructions in a scoreboard of configurable depth and selects the nearest producer for each decode-stage source operand. It also generates load-use stalls for a configurable load latency, multi-cycle flushes after a PC redirect, and a whole-pipe freeze while memory is busy. It sits beside the datapath and drives the IF/ID and ID/EX register controls and the EX operand bypass muxes.

## Interface
- AWIDTH, 5, register address width
- FWD_DEPTH, 2, number of older in-flight instructions tracked and forwardable (1..4)
- LOAD_LAT, 1, cycles after a load enters EX before its data is forwardable (1..3, must be < FWD_DEPTH+1)
- FLUSH_DEPTH, 2, cycles of flush after a redirect (1..4)
- CNT_WIDTH, 16, width of the stall performance counter
- FW (derived), clog2(FWD_DEPTH+1), width of the forward select codes
- hc_clk  in  1  clock; all state is updated on the rising edge
- hc_rst  in  1  asynchronous, active-low reset
- hc_i_ce  in  1  block enable; when low, the scoreboard clears and all outputs are 0
- hc_i_valid_id  in  1  the ID stage holds a real instruction
- hc_i_rs, hc_i_rt  in  AWIDTH  ID source register addresses
- hc_i_use_rs, hc_i_use_rt  in  1  the ID instruction reads rs / rt
- hc_i_regwr  in  1  the ID instruction writes a register
- hc_i_rd  in  AWIDTH  ID destination address (after the rt/rd selection)
- hc_i_is_load  in  1  the ID instruction is a load
- hc_i_redirect  in  1  EX changes the PC (taken branch, j, jal, jr)
- hc_i_mem_busy  in  1  the data memory cannot complete this cycle
- hc_o_stall_if  out  1  hold the PC and the IF/ID register
- hc_o_bubble_ex  out  1  load zeros/controls-off into the ID/EX register
- hc_o_flush  out  1  clear IF/ID and ID/EX to bubbles
- hc_o_freeze  out  1  hold every pipeline register
- hc_o_fwd_rs, hc_o_fwd_rt  out  FW  0 = register file; k+1 = result of the producer in scoreboard slot k
- hc_o_stall_cnt  out  CNT_WIDTH  count of load-use stall cycles, saturating

## Operation
- The scoreboard has FWD_DEPTH slots. Each slot holds {valid, wr, rd, load}.
  - Slot 0 is the instruction directly ahead of ID, currently in EX.
  - Slot k is the instruction k stages further on.
- Match rule: slot k matches source s when valid && wr && rd==s && s!=0 && the matching use bit is set.
  - fwd = (lowest matching k)+1. With no match, fwd = 0.
  - A producer with rd==0 is recorded with wr=0.
- Load-use stall: the lowest matching slot k has load=1 and k < LOAD_LAT.
  - Asserts stall_if=1 and bubble_ex=1.
  - The fwd outputs still show the match.
- Priority, highest first:
  1. !ce
  2. freeze (mem_busy)
  3. flush (redirect or flush counter non-zero)
  4. load-use stall
  5. normal issue
- Freeze:
  - freeze=1 and stall_if=1; bubble_ex=0 and flush=0.
  - The scoreboard, flush counter and stall counter all hold.
  - A redirect held by EX during a freeze is acted on in the first cycle after mem_busy falls. The source keeps redirect asserted because EX is frozen.
- Flush FSM with states RUN and FLUSH, and counter fcnt:
  - Redirect in RUN: flush=1 that cycle, go to FLUSH with fcnt=FLUSH_DEPTH-1.
  - FLUSH: flush=1 while fcnt>0; decrement each cycle; return to RUN at 0.
  - If FLUSH_DEPTH=1, stay in RUN.
  - Redirect while in FLUSH reloads fcnt=FLUSH_DEPTH-1.
  - Flush forces stall_if=0 and bubble_ex=0. The flush itself squashes the stages.
- Scoreboard update, on every non-frozen cycle with ce=1:
  - Slots shift (slot k ← slot k-1; the oldest slot is dropped).
  - Slot 0 ← {1, regwr&&rd!=0, rd, is_load} when issued; otherwise all zero.
  - issued = valid_id && !stall && !flush.
- stall_cnt increments by 1 on each load-use stall cycle and saturates at all ones. Freeze and flush cycles are not counted.

## Timing
- stall_if, bubble_ex, flush, freeze and the fwd codes are combinational from the current inputs and the registered state, valid in the same cycle.
- The scoreboard, FSM, fcnt and stall_cnt update on the rising edge of hc_clk.
- Producer-to-consumer forwarding has zero added latency. A dependent instruction in the cycle right after its producer issues sees fwd=1.
- A load-use stall lasts LOAD_LAT-k cycles for a load at slot k. Its bubbles advance the load each cycle.
- A redirect gives exactly FLUSH_DEPTH consecutive flush cycles (without freeze).
- Reset (asynchronous, while hc_rst is low):
  - Scoreboard all zero, state RUN, fcnt=0, stall_cnt=0.
  - All outputs are 0.
  - A reset in the middle of a flush or stall aborts it.
- ce falling: the scoreboard clears on the next edge and the FSM returns to RUN. stall_cnt is kept.

## Test plan
- Reset: assert hc_rst=0 mid-flush with stall_cnt=5 -> all outputs 0, stall_cnt=0; after release with valid_id=0, no flush.
- ALU chain with defaults: issue rd=3, then use rs=3 -> fwd_rs=1. Issue rd=3, one independent instruction, then use rs=3 -> fwd_rs=2. A gap of 2 independent instructions -> fwd_rs=0.
- Load-use with LOAD_LAT=1: load rd=5, then use rt=5 -> stall_if=bubble_ex=1 for exactly 1 cycle; the next cycle shows fwd_rt=2 with no stall; stall_cnt=1.
- Redirect with FLUSH_DEPTH=2, together with a pending load-use -> flush=1 for 2 cycles, stall_if=0, and slot 0 gets bubbles (a later use of that rd gives fwd=0 if the load was squashed).
- mem_busy for 3 cycles with rs matching slot 0 -> freeze=1 and stall_if=1 for 3 cycles, fwd_rs=1 stable, bubble_ex=0, scoreboard unchanged afterwards.
- Priority and r0: producers of r4 in slots 0 and 1 -> fwd=1; a producer with rd=0 and use rs=0 -> fwd=0 and no stall; stall_cnt held at all ones keeps saturating.
